// File: rtl/bus_alu_coproc_if.sv
// bus_alu_coproc_if: control, operand-fetch and writeback signals between a bus owner and the ALU coprocessor
interface bus_alu_coproc_if #(parameter int WIDTH = 4);
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] imm;
  logic [3:0]       bus_req;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_in;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] bus_oe;
  logic             oe_n;
  logic             carry;
  logic             zero;
  logic             busy;
  logic             done;
  logic             err;
  modport master (
    output start, opcode, imm, bus_ready, bus_in, oe_n,
    input  bus_req, bus_out, bus_oe, carry, zero, busy, done, err
  );
  modport slave (
    input  start, opcode, imm, bus_ready, bus_in, oe_n,
    output bus_req, bus_out, bus_oe, carry, zero, busy, done, err
  );
endinterface

// File: rtl/bus_alu_coproc.sv
// bus_alu_coproc: latches opcode/imm, fetches operand B over the bus, runs one of eight ALU ops and writes the result back
module bus_alu_coproc #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  bus_alu_coproc_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(TIMEOUT + 1) + 1;
  typedef enum logic [2:0] {IDLE, REQ, FETCH, EXEC, WB, DONE} state_t;
  state_t           state;
  logic [3:0]       op;
  logic [WIDTH-1:0] a, b;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   ax, bx, res;
  logic             cy, expired, alu_op;
  assign ax      = {1'b0, a};
  assign bx      = {1'b0, b};
  assign alu_op  = op inside {[4'd1:4'd8]};
  assign expired = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
  always_comb begin
    res = '0;
    case (op)
      4'd1:       res = ax + bx;
      4'd2, 4'd8: res = ax - bx;
      4'd3:       res = ax & bx;
      4'd4:       res = ax | bx;
      4'd5:       res = ax ^ bx;
      4'd6:       res = {1'b0, a << b[SW-1:0]};
      4'd7:       res = {1'b0, a >> b[SW-1:0]};
      default:    res = '0;
    endcase
    cy = (op == 4'd1) ? res[WIDTH] : (op == 4'd2 || op == 4'd8) ? ~res[WIDTH] : 1'b0;
  end
  // cnt clears on every transition; only the waiting branches keep it running
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op          <= '0;
      a           <= '0;
      b           <= '0;
      cnt         <= '0;
      bus.bus_req <= '0;
      bus.bus_out <= '0;
      bus.bus_oe  <= '0;
      bus.carry   <= 1'b0;
      bus.zero    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        IDLE: if (bus.start) begin
          op       <= bus.opcode;
          a        <= bus.imm;
          bus.busy <= 1'b1;
          if (bus.opcode inside {[4'd1:4'd8]}) begin
            state       <= REQ;
            bus.bus_req <= 4'b0011;
          end else state <= EXEC;
        end
        REQ: if (bus.bus_ready) begin
          state       <= FETCH;
          bus.bus_req <= 4'b0001;
        end else if (expired) begin
          state       <= DONE;
          bus.bus_req <= '0;
          bus.done    <= 1'b1;
          bus.err     <= 1'b1;
        end else cnt <= cnt + CW'(1);
        FETCH: if (bus.bus_ready) begin
          state       <= EXEC;
          b           <= bus.bus_in;
          bus.bus_req <= '0;
        end else if (expired) begin
          state       <= DONE;
          bus.bus_req <= '0;
          bus.done    <= 1'b1;
          bus.err     <= 1'b1;
        end else cnt <= cnt + CW'(1);
        // NOP and illegal opcodes pass through here without touching flags or bus_out
        EXEC: begin
          if (alu_op) begin
            bus.carry <= cy;
            bus.zero  <= (res[WIDTH-1:0] == '0);
          end
          if (alu_op && op != 4'd8) begin
            state       <= WB;
            bus.bus_out <= res[WIDTH-1:0];
            bus.bus_oe  <= '1;
          end else begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.err  <= (op > 4'd8);
          end
        end
        WB: if (!bus.oe_n || expired) begin
          state      <= DONE;
          bus.bus_oe <= '0;
          bus.done   <= 1'b1;
          bus.err    <= bus.oe_n;
        end else cnt <= cnt + CW'(1);
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
